// File: rtl/mult_row_sequencer.sv
// rtl/mult_row_sequencer.sv - runs one row multiply per output row, stores results, tracks argmax
// Optional WAIT-state watchdog: define MULT_SEQ_WATCHDOG_EN.
module mult_row_sequencer #(
    parameter int NUM_ROWS       = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    output logic        busy,
    output logic [3:0]  mult_row_select,
    output logic        mult_begin,
    input  logic        mult_done_row,
    input  logic [31:0] mult_row_result,
    input  logic        mult_overflow,
    output logic        res_wr_en,
    output logic [3:0]  res_wr_addr,
    output logic [31:0] res_wr_data,
    output logic [3:0]  class_out,
    output logic        class_valid,
    output logic        ovf_any,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);

    if (NUM_ROWS < 1 || NUM_ROWS > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mult_row_sequencer: NUM_ROWS must be 1..16 and TIMEOUT_CYCLES >= 1");
    end

    state_t      r_state;
    logic [3:0]  r_row;
    logic [31:0] r_captured;
    logic [31:0] r_best;
    logic [3:0]  r_best_idx;
    logic [3:0]  r_class;
    logic        r_busy;
    logic        r_begin;
    logic        r_wr_en;
    logic        r_class_valid;
    logic        r_ovf_any;
    logic        w_new_best;

`ifdef MULT_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout;

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    // Row 0 always seeds the maximum; strict compare keeps the lower index on ties.
    assign w_new_best = (r_row == 4'd0) || (r_captured > r_best);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state       <= S_IDLE;
            r_row         <= 4'd0;
            r_captured    <= 32'h0;
            r_best        <= 32'h0;
            r_best_idx    <= 4'd0;
            r_class       <= 4'd0;
            r_busy        <= 1'b0;
            r_begin       <= 1'b0;
            r_wr_en       <= 1'b0;
            r_class_valid <= 1'b0;
            r_ovf_any     <= 1'b0;
`ifdef MULT_SEQ_WATCHDOG_EN
            r_wd_cnt      <= '0;
            r_timeout     <= 1'b0;
`endif
        end else begin
            r_begin       <= 1'b0;
            r_wr_en       <= 1'b0;
            r_class_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row     <= 4'd0;
                        r_ovf_any <= 1'b0;
`ifdef MULT_SEQ_WATCHDOG_EN
                        r_timeout <= 1'b0;
`endif
                        r_busy    <= 1'b1;
                        r_begin   <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef MULT_SEQ_WATCHDOG_EN
                    r_wd_cnt <= '0;
`endif
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (mult_done_row) begin
                        r_captured <= mult_overflow ? 32'hFFFF_FFFF : mult_row_result;
                        if (mult_overflow) begin
                            r_ovf_any <= 1'b1;
                        end
                        r_wr_en <= 1'b1;
                        r_state <= S_STORE;
                    end
`ifdef MULT_SEQ_WATCHDOG_EN
                    // Abandon the run: no store, no class update, class_out keeps its old value.
                    else if (r_wd_cnt == WD_LAST) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WD_W'(1);
                    end
`endif
                end
                S_STORE: begin
                    if (w_new_best) begin
                        r_best     <= r_captured;
                        r_best_idx <= r_row;
                    end
                    if (r_row == LAST_ROW) begin
                        r_state <= S_DONE;
                    end else begin
                        r_row   <= r_row + 4'd1;
                        r_begin <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_class       <= r_best_idx;
                    r_class_valid <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign mult_row_select = r_row;
    assign mult_begin      = r_begin;
    assign res_wr_en       = r_wr_en;
    assign res_wr_addr     = r_row;
    assign res_wr_data     = r_captured;
    assign class_out       = r_class;
    assign class_valid     = r_class_valid;
    assign ovf_any         = r_ovf_any;

endmodule

// File: tb/tb_mult_row_sequencer.sv
// tb/tb_mult_row_sequencer.sv - directed table-driven bench for mult_row_sequencer
// Watchdog scenario is exercised when MULT_SEQ_WATCHDOG_EN is defined.
module tb_mult_row_sequencer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic        busy;
    logic [3:0]  mult_row_select;
    logic        mult_begin;
    logic        mult_done_row;
    logic [31:0] mult_row_result;
    logic        mult_overflow;
    logic        res_wr_en;
    logic [3:0]  res_wr_addr;
    logic [31:0] res_wr_data;
    logic [3:0]  class_out;
    logic        class_valid;
    logic        ovf_any;
    logic        timeout;

    mult_row_sequencer #(
        .NUM_ROWS      (10),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start          (start),
        .busy           (busy),
        .mult_row_select(mult_row_select),
        .mult_begin     (mult_begin),
        .mult_done_row  (mult_done_row),
        .mult_row_result(mult_row_result),
        .mult_overflow  (mult_overflow),
        .res_wr_en      (res_wr_en),
        .res_wr_addr    (res_wr_addr),
        .res_wr_data    (res_wr_data),
        .class_out      (class_out),
        .class_valid    (class_valid),
        .ovf_any        (ovf_any),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:9][31:0] vals;
        logic [3:0]       ovf_row;
        logic [9:0]       lat;
        logic [3:0]       exp_class;
        logic             exp_ovf;
        logic             poke;
    } vec_t;

    vec_t vecs [5];

    int n_checks = 0;
    int n_errors = 0;

    // Multiplier model state
    logic [0:9][31:0] mdl_vals = '0;
    int               mdl_ovf_row = 15;
    int               mdl_lat = 1;
    int               mdl_hang_row = 15;
    logic             spur_req = 1'b0;
    logic             mdl_busy = 1'b0;
    int               mdl_cnt = 0;
    logic [3:0]       mdl_row = 4'd0;
    int               beg_total = 0;

    // Output monitor state
    logic [3:0]  wlog_addr [128];
    logic [31:0] wlog_data [128];
    int          wr_total = 0;
    int          cv_total = 0;
    logic        last_busy = 1'b0;
    logic        cv_prev_busy = 1'b0;

    always @(negedge clk) begin
        mult_done_row   = 1'b0;
        mult_overflow   = 1'b0;
        mult_row_result = 32'h0;
        if (spur_req) begin
            mult_done_row   = 1'b1;
            mult_row_result = 32'hDEAD_0001;
        end
        if (mdl_busy) begin
            if (mdl_cnt <= 0) begin
                mult_done_row   = 1'b1;
                mult_row_result = mdl_vals[mdl_row];
                mult_overflow   = (int'(mdl_row) == mdl_ovf_row);
                mdl_busy        = 1'b0;
            end else begin
                mdl_cnt = mdl_cnt - 1;
            end
        end
        if (mult_begin) begin
            beg_total = beg_total + 1;
            if (int'(mult_row_select) != mdl_hang_row) begin
                mdl_busy = 1'b1;
                mdl_cnt  = mdl_lat - 1;
                mdl_row  = mult_row_select;
            end
        end
    end

    always @(negedge clk) begin
        if (res_wr_en) begin
            wlog_addr[wr_total % 128] = res_wr_addr;
            wlog_data[wr_total % 128] = res_wr_data;
            wr_total = wr_total + 1;
        end
        if (class_valid) begin
            cv_total     = cv_total + 1;
            cv_prev_busy = last_busy;
        end
        last_busy = busy;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_row_select"}, mult_row_select, 0);
        chk({tag, "_begin"}, mult_begin, 0);
        chk({tag, "_wr_en"}, res_wr_en, 0);
        chk({tag, "_wr_addr"}, res_wr_addr, 0);
        chk({tag, "_wr_data"}, res_wr_data, 0);
        chk({tag, "_class_out"}, class_out, 0);
        chk({tag, "_class_valid"}, class_valid, 0);
        chk({tag, "_ovf_any"}, ovf_any, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        int          wb;
        int          cb;
        int          bb;
        int          k;
        logic [31:0] exp_d;
        string       tag;
        v   = vecs[idx];
        tag = $sformatf("v%0d", idx);
        mdl_vals    = v.vals;
        mdl_ovf_row = int'(v.ovf_row);
        mdl_lat     = int'(v.lat);
        wb = wr_total;
        cb = cv_total;
        bb = beg_total;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_on_accept"}, busy, 1);
        chk({tag, "_begin_row0"}, {mult_begin, mult_row_select}, {1'b1, 4'd0});
        chk({tag, "_ovf_cleared"}, ovf_any, 0);
        chk({tag, "_timeout_cleared"}, timeout, 0);
        if (v.poke) begin
            tick();
            tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        k = 0;
        while (cv_total == cb && k < 20000) begin
            tick();
            k = k + 1;
        end
        chk({tag, "_class_valid_count"}, cv_total - cb, 1);
        chk({tag, "_busy_in_done"}, cv_prev_busy, 1);
        chk({tag, "_busy_low_after_done"}, busy, 0);
        chk({tag, "_class_out"}, class_out, v.exp_class);
        chk({tag, "_ovf_any"}, ovf_any, v.exp_ovf);
        chk({tag, "_write_count"}, wr_total - wb, 10);
        chk({tag, "_begin_count"}, beg_total - bb, 10);
        for (int i = 0; i < 10; i++) begin
            exp_d = (i == int'(v.ovf_row)) ? 32'hFFFF_FFFF : v.vals[i];
            chk($sformatf("%s_wr_addr%0d", tag, i), wlog_addr[(wb + i) % 128], i);
            chk($sformatf("%s_wr_data%0d", tag, i), wlog_data[(wb + i) % 128], exp_d);
        end
        tick();
        chk({tag, "_class_valid_one_cycle"}, class_valid, 0);
        chk({tag, "_class_held"}, class_out, v.exp_class);
        chk({tag, "_ovf_held"}, ovf_any, v.exp_ovf);
    endtask

    initial begin
        int   wb;
        int   bb;
        int   cb;
        int   k;
        logic early;

        vecs[0] = '{vals: {32'd5, 32'd9, 32'd3, 32'd9, 32'd1, 32'd0, 32'd2, 32'd8, 32'd7, 32'd4},
                    ovf_row: 4'd15, lat: 10'd400, exp_class: 4'd1, exp_ovf: 1'b0, poke: 1'b1};
        vecs[1] = '{vals: {32'd5, 32'd9, 32'd3, 32'd9, 32'h10, 32'd0, 32'd2, 32'd8, 32'd7, 32'd4},
                    ovf_row: 4'd4, lat: 10'd3, exp_class: 4'd4, exp_ovf: 1'b1, poke: 1'b0};
        vecs[2] = '{vals: '0,
                    ovf_row: 4'd15, lat: 10'd1, exp_class: 4'd0, exp_ovf: 1'b0, poke: 1'b0};
        vecs[3] = '{vals: {32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
                    ovf_row: 4'd15, lat: 10'd2, exp_class: 4'd0, exp_ovf: 1'b0, poke: 1'b0};
        vecs[4] = '{vals: {32'd3, 32'd1, 32'd4, 32'd1, 32'd5, 32'd9, 32'd2, 32'd6, 32'd5, 32'd9},
                    ovf_row: 4'd15, lat: 10'd7, exp_class: 4'd5, exp_ovf: 1'b0, poke: 1'b0};

        n_rst = 1'b0;
        start = 1'b0;
        tick();
        tick();
        tick();
        n_rst = 1'b1;
        chk_all_zero("reset");

        // done_row while idle must be ignored
        wb = wr_total;
        bb = beg_total;
        spur_req = 1'b1;
        tick();
        spur_req = 1'b0;
        tick();
        tick();
        chk("spur_no_write", wr_total - wb, 0);
        chk("spur_no_begin", beg_total - bb, 0);
        chk("spur_stays_idle", busy, 0);

        run_vec(0);
        run_vec(1);
        repeat (5) tick();
        chk("ovf_sticky_idle", ovf_any, 1);
        run_vec(2);
        run_vec(3);

        // reset during WAIT of row 6
        mdl_vals    = vecs[0].vals;
        mdl_ovf_row = 15;
        mdl_lat     = 10;
        wb = wr_total;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!(mult_row_select == 4'd6 && busy && !mult_begin && !res_wr_en) && k < 2000) begin
            tick();
            k = k + 1;
        end
        chk("midrst_reached_row6", (k < 2000), 1);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        chk_all_zero("midrst");
        repeat (20) tick();
        chk("midrst_no_row6_write", wr_total - wb, 6);
        chk("midrst_stays_idle", busy, 0);

        run_vec(4);

`ifdef MULT_SEQ_WATCHDOG_EN
        mdl_vals     = vecs[4].vals;
        mdl_ovf_row  = 15;
        mdl_lat      = 3;
        mdl_hang_row = 2;
        wb = wr_total;
        cb = cv_total;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!(mult_row_select == 4'd2 && mult_begin) && k < 2000) begin
            tick();
            k = k + 1;
        end
        chk("wd_reached_row2", (k < 2000), 1);
        early = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (timeout !== 1'b0 || busy !== 1'b1) early = 1'b1;
        end
        chk("wd_not_early", early, 0);
        tick();
        chk("wd_timeout_set", timeout, 1);
        chk("wd_busy_low", busy, 0);
        chk("wd_rows_written", wr_total - wb, 2);
        chk("wd_no_class_valid", cv_total - cb, 0);
        chk("wd_class_kept", class_out, vecs[4].exp_class);
        mdl_hang_row = 15;
        repeat (5) tick();
        chk("wd_timeout_sticky", timeout, 1);
        run_vec(2);
`else
        repeat (5) tick();
        chk("timeout_tied_low", timeout, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
